// File: rtl/blockram_fifo_controller_pkg.sv
// Shared definitions for the block-RAM FIFO controller.
//   BYTE_LEN_IN_BITS : bits per RAM byte lane (sets the byte-enable width)
//   buf_op_e         : push/pop encoding used by the output skid buffer
package blockram_fifo_controller_pkg;

    localparam int unsigned BYTE_LEN_IN_BITS = 8;

    // Encoded as {push, pop} so the pair of strobes can be cast directly.
    typedef enum logic [1:0] {
        BufIdle    = 2'b00,
        BufPop     = 2'b01,
        BufPush    = 2'b10,
        BufPushPop = 2'b11
    } buf_op_e;

endpackage

// File: rtl/fifo_skid_buffer.sv
// Two-entry register FIFO that absorbs the block RAM read latency.
//   clk_in, reset_in : clock, asynchronous active-high reset
//   push_in/push_data_in : write one entry
//   pop_in           : drop the head entry
//   count_out        : occupancy 0..2
//   head_out         : oldest entry (registered, zero when empty after reset)
module fifo_skid_buffer
    import blockram_fifo_controller_pkg::*;
#(
    parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  push_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] push_data_in,
    input  logic                                  pop_in,
    output logic [1:0]                            count_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] head_out
);

    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] entry_q [2];
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] entry_d [2];
    logic [1:0]                            count_q, count_d;
    buf_op_e                               op;

    assign op = buf_op_e'({push_in, pop_in});

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        unique case (op)
            BufIdle: ;
            BufPush: begin
                entry_d[count_q[0]] = push_data_in;
                count_d             = count_q + 2'd1;
            end
            BufPop: begin
                entry_d[0] = entry_q[1];
                count_d    = count_q - 2'd1;
            end
            BufPushPop: begin
                if (count_q == 2'd2) begin
                    entry_d[0] = entry_q[1];
                    entry_d[1] = push_data_in;
                end else begin
                    entry_d[0] = push_data_in;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            count_q    <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign head_out  = entry_q[0];

    push_no_overflow: assert property (@(posedge clk_in) disable iff (reset_in)
        !(push_in && !pop_in && count_q == 2'd2));
    pop_no_underflow: assert property (@(posedge clk_in) disable iff (reset_in)
        !(pop_in && count_q == 2'd0));

endmodule

// File: rtl/blockram_fifo_controller.sv
// Valid/ack FIFO controller driving an external byte-masked, read-first,
// single-cycle-latency dual-port block RAM, with a 2-entry output skid buffer.
//   Producer side : request_valid_in, request_in, issue_ack_out
//   Consumer side : request_valid_out, request_out, issue_ack_in
//   RAM write     : ram_write_access_en_out, ram_write_en_out, _set_addr_out, _data_out
//   RAM read      : ram_read_access_en_out, ram_read_set_addr_out, ram_read_data_in
//   Status        : fifo_count_out, full_out, empty_out
// Optional macro BLOCKRAM_FIFO_BYPASS_EN: when the RAM path is empty, enqueued
// entries go straight into the skid buffer (1-cycle enqueue-to-valid latency).
module blockram_fifo_controller
    import blockram_fifo_controller_pkg::*;
#(
    parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int unsigned NUM_SET                    = 64,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int unsigned WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  request_valid_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    output logic                                  issue_ack_out,
    output logic                                  request_valid_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
    input  logic                                  issue_ack_in,
    output logic                                  ram_write_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      ram_write_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_write_data_out,
    output logic                                  ram_read_access_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      ram_read_set_addr_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_read_data_in,
    output logic [SET_PTR_WIDTH_IN_BITS+1:0]      fifo_count_out,
    output logic                                  full_out,
    output logic                                  empty_out
);

    localparam int unsigned CntW = SET_PTR_WIDTH_IN_BITS + 2;
    localparam logic [SET_PTR_WIDTH_IN_BITS:0] RamFull = NUM_SET[SET_PTR_WIDTH_IN_BITS:0];
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] PtrOne = SET_PTR_WIDTH_IN_BITS'(1);
    localparam logic [SET_PTR_WIDTH_IN_BITS:0] RamCntOne = (SET_PTR_WIDTH_IN_BITS + 1)'(1);

    logic [SET_PTR_WIDTH_IN_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SET_PTR_WIDTH_IN_BITS:0]   ram_count_q, ram_count_d;
    logic                             inflight_q, inflight_d;

    logic                                  enq, deq, bypass, ram_wr, issue_rd;
    logic [1:0]                            buf_count;
    logic                                  buf_push;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] buf_push_data;

    assign full_out      = (ram_count_q == RamFull);
    assign issue_ack_out = !full_out && !reset_in;
    assign enq           = request_valid_in && issue_ack_out;
    assign deq           = request_valid_out && issue_ack_in;

    always_comb begin
`ifdef BLOCKRAM_FIFO_BYPASS_EN
        // Only bypass when nothing older is in the RAM or in flight, so order holds.
        bypass = enq && (ram_count_q == '0) && !inflight_q &&
                 ({1'b0, buf_count} < (3'd2 + {2'b0, deq}));
`else
        bypass = 1'b0;
`endif
        ram_wr = enq && !bypass;
        // Registered ram_count: a word written this cycle is never read this cycle,
        // which keeps the read-first RAM from returning stale data.
        issue_rd = (ram_count_q != '0) &&
                   (({1'b0, buf_count} + {2'b0, inflight_q}) <= (3'd1 + {2'b0, deq}));
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        inflight_d  = issue_rd;
        if (ram_wr) wr_ptr_d = wr_ptr_q + PtrOne;
        if (issue_rd) rd_ptr_d = rd_ptr_q + PtrOne;
        if (ram_wr && !issue_rd) begin
            ram_count_d = ram_count_q + RamCntOne;
        end else if (!ram_wr && issue_rd) begin
            ram_count_d = ram_count_q - RamCntOne;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            inflight_q  <= inflight_d;
        end
    end

    // Returning RAM data and bypassed entries are mutually exclusive (bypass needs !inflight).
    assign buf_push      = inflight_q || bypass;
    assign buf_push_data = inflight_q ? ram_read_data_in : request_in;

    fifo_skid_buffer #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(SINGLE_ENTRY_WIDTH_IN_BITS)
    ) u_skid (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .push_in      (buf_push),
        .push_data_in (buf_push_data),
        .pop_in       (deq),
        .count_out    (buf_count),
        .head_out     (request_out)
    );

    assign request_valid_out = (buf_count != 2'd0);

    assign ram_write_access_en_out = ram_wr;
    assign ram_write_en_out        = {WRITE_MASK_LEN{ram_wr}};
    assign ram_write_set_addr_out  = wr_ptr_q;
    assign ram_write_data_out      = request_in;
    assign ram_read_access_en_out  = issue_rd;
    assign ram_read_set_addr_out   = rd_ptr_q;

    assign fifo_count_out = {1'b0, ram_count_q} + {{(CntW-1){1'b0}}, inflight_q} +
                            {{(CntW-2){1'b0}}, buf_count};
    assign empty_out      = (fifo_count_out == '0);

endmodule

// File: tb/tb_blockram_fifo_controller.sv
module tb_blockram_fifo_controller;

    localparam int W = 64;
    localparam int N = 64;
    localparam int A = 6;
    localparam int M = 8;
`ifdef BLOCKRAM_FIFO_BYPASS_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 3;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic [W-1:0] req_in = '0;
    logic         ack_out;
    logic         valid_out;
    logic [W-1:0] req_out;
    logic         ack_in = 1'b0;
    logic         wr_acc;
    logic [M-1:0] wr_mask;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         rd_acc;
    logic [A-1:0] rd_addr;
    logic [W-1:0] rd_data;
    logic [A+1:0] count;
    logic         full;
    logic         empty;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int deq_cnt = 0;
    int last_deq_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mem [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    blockram_fifo_controller dut (
        .clk_in                  (clk),
        .reset_in                (rst),
        .request_valid_in        (valid_in),
        .request_in              (req_in),
        .issue_ack_out           (ack_out),
        .request_valid_out       (valid_out),
        .request_out             (req_out),
        .issue_ack_in            (ack_in),
        .ram_write_access_en_out (wr_acc),
        .ram_write_en_out        (wr_mask),
        .ram_write_set_addr_out  (wr_addr),
        .ram_write_data_out      (wr_data),
        .ram_read_access_en_out  (rd_acc),
        .ram_read_set_addr_out   (rd_addr),
        .ram_read_data_in        (rd_data),
        .fifo_count_out          (count),
        .full_out                (full),
        .empty_out               (empty)
    );

    // Read-first dual-port RAM model with byte enables and 1-cycle read latency.
    initial begin
        for (int i = 0; i < N; i++) mem[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
        rd_data = '0;
    end
    always @(posedge clk) begin
        if (rd_acc) rd_data <= mem[rd_addr];
        if (wr_acc) begin
            for (int b = 0; b < M; b++) begin
                if (wr_mask[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: entries held must match the count, and every dequeue the oldest entry.
    always @(negedge clk) begin
        if (!rst) begin
            check("fifo_count", 64'(count), 64'(exp_q.size()));
            if (valid_in && ack_out) exp_q.push_back(req_in);
            if (valid_out && ack_in) begin
                deq_cnt++;
                last_deq_cyc = cyc;
                if (exp_q.size() == 0) check("deq_unexpected", 64'(req_out), 64'hFFFF_FFFF);
                else check("deq_data", req_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int g = 0; g < 300 && !empty; g++) tick();
        check(tag, 64'(empty), 64'd1);
        check({tag, "_sb"}, 64'(exp_q.size()), 64'd0);
    endtask

    int acc;
    int start_cyc;
    int g;

    initial begin
        // Reset state
        valid_in = 1'b1;
        req_in   = 64'h1234;
        repeat (3) tick();
        check("rst_ack", 64'(ack_out), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_data", req_out, 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_wr_en", 64'(wr_acc), 64'd0);
        check("rst_rd_en", 64'(rd_acc), 64'd0);
        valid_in = 1'b0;
        rst = 1'b0;
        tick();

        // Single write 0xA5A5
        valid_in = 1'b1;
        req_in   = 64'hA5A5;
        ack_in   = 1'b1;
        #2;
        check("t1_ack", 64'(ack_out), 64'd1);
`ifdef BLOCKRAM_FIFO_BYPASS_EN
        check("t1_no_wr", 64'(wr_acc), 64'd0);
        tick();
        valid_in = 1'b0;
        #2;
        check("t1_valid1", 64'(valid_out), 64'd1);
        check("t1_data1", req_out, 64'hA5A5);
        tick();
        check("t1_empty", 64'(empty), 64'd1);
`else
        check("t1_wr_en", 64'(wr_acc), 64'd1);
        check("t1_wr_mask", 64'(wr_mask), 64'hFF);
        check("t1_wr_addr", 64'(wr_addr), 64'd0);
        check("t1_wr_data", wr_data, 64'hA5A5);
        check("t1_rd_en0", 64'(rd_acc), 64'd0);
        tick();
        valid_in = 1'b0;
        #2;
        check("t1_rd_en1", 64'(rd_acc), 64'd1);
        check("t1_rd_addr", 64'(rd_addr), 64'd0);
        check("t1_valid1", 64'(valid_out), 64'd0);
        tick();
        check("t1_valid2", 64'(valid_out), 64'd0);
        check("t1_count2", 64'(count), 64'd1);
        tick();
        check("t1_valid3", 64'(valid_out), 64'd1);
        check("t1_data3", req_out, 64'hA5A5);
        tick();
        check("t1_empty", 64'(empty), 64'd1);
`endif

        // Continuous enqueue of 200 entries, consumer always ready
        acc = 0;
        g = 0;
        deq_cnt = 0;
        start_cyc = cyc;
        while (acc < 200 && g < 400) begin
            valid_in = 1'b1;
            req_in   = 64'hC0DE_0000_0000_0000 | 64'(acc);
            #2;
            if (ack_out) acc++;
            tick();
            g++;
        end
        valid_in = 1'b0;
        check("t2_accepted", 64'(acc), 64'd200);
        drain("t2_drain");
        check("t2_deq_cnt", 64'(deq_cnt), 64'd200);
        check("t2_last_cyc", 64'(last_deq_cyc - start_cyc), 64'(199 + Lat));

        // Fill to 66 with the consumer stalled
        ack_in = 1'b0;
        acc = 0;
        g = 0;
        while (acc < 66 && g < 300) begin
            valid_in = 1'b1;
            req_in   = 64'h3300_0000_0000_0000 | 64'(acc);
            #2;
            if (ack_out) acc++;
            tick();
            g++;
        end
        valid_in = 1'b0;
        check("t3_accepted", 64'(acc), 64'd66);
        repeat (4) tick();
        check("t3_count", 64'(count), 64'd66);
        check("t3_full", 64'(full), 64'd1);
        check("t3_ack", 64'(ack_out), 64'd0);
        valid_in = 1'b1;
        req_in   = 64'hBAD;
        #2;
        check("t3_ack_blocked", 64'(ack_out), 64'd0);
        tick();
        valid_in = 1'b0;
        ack_in   = 1'b1;
        #2;
        check("t3_ack_same_cyc", 64'(ack_out), 64'd0);
        tick();
        check("t3_ack_next_cyc", 64'(ack_out), 64'd1);
        drain("t3_drain");

        // Random valid/ack traffic
        for (int i = 0; i < 10000; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            req_in   = {$urandom, $urandom};
            ack_in   = (i % 2000 < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_in = 1'b0;
        ack_in   = 1'b1;
        drain("t4_drain");

        // Reset mid-stream while a RAM read is in flight
        ack_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            req_in   = 64'h5700 | 64'(i);
            tick();
        end
        valid_in = 1'b0;
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_valid", 64'(valid_out), 64'd0);
        check("t5_data", req_out, 64'd0);
        check("t5_ack", 64'(ack_out), 64'd0);
        check("t5_count", 64'(count), 64'd0);
        check("t5_empty", 64'(empty), 64'd1);
        check("t5_rd_en", 64'(rd_acc), 64'd0);
        tick();
        rst    = 1'b0;
        ack_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_stale", 64'(valid_out), 64'd0);
            check("t5_empty_after", 64'(empty), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
